// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the sequence-detector scheduler.
// The state encoding is visible to the arbiter enable and to the bench through busy.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    RESP
  } sched_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 4;

endpackage : seq_det_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, wrapping.
// Purely combinational; the owner of ptr decides when to advance it.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  int   idx;
  logic found;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/seq_det_scheduler.sv
// Time-shares one serial 1011 detector between NUM_REQ byte-wide requesters and
// returns {id, match count} for each served word on a valid/ready response port.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        det_rst,
  output logic                        det_in,
  input  logic                        det_out,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [CNT_W-1:0]            rsp_count,
  input  logic                        rsp_ready,
  output logic                        busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  sched_state_t      state_q,     state_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              det_rst_q,   det_rst_d;
  logic              det_in_q,    det_in_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (state_q == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign det_rst   = det_rst_q;
  assign det_in    = det_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_count = count_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_id_d    = rsp_id_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    det_rst_d   = 1'b0;
    det_in_d    = 1'b0;

    // The detector output lags its input by one clock, so DRAIN still counts.
    if ((state_q == SHIFT || state_q == DRAIN) && det_out && count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          shreg_d   = req_data[int'(gnt_id)*DATA_W +: DATA_W];
          rsp_id_d  = gnt_id;
          rr_ptr_d  = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
          count_d   = '0;
          det_rst_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        // First bit is launched on the way out so SHIFT spans exactly DATA_W cycles.
        det_in_d  = shreg_q[DATA_W-1];
        shreg_d   = shreg_q << 1;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DRAIN;
        end else begin
          det_in_d  = shreg_q[DATA_W-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      DRAIN: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_id_q    <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      det_rst_q   <= 1'b1;
      det_in_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_id_q    <= rsp_id_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      det_rst_q   <= det_rst_d;
      det_in_q    <= det_in_d;
    end
  end

endmodule : seq_det_scheduler

// File: tb/tb_seq_det_scheduler.sv
// Directed bench: scheduler paired with a behavioural overlapping 1011 detector
// (registered match output, synchronous active-high clear).
module tb_seq_det_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              det_rst;
  logic              det_in;
  logic              det_out;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [CW-1:0]     rsp_count;
  logic              rsp_ready;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_scheduler #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_rst   (det_rst),
    .det_in    (det_in),
    .det_out   (det_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Detector states: 0 = none, 1 = "1", 2 = "10", 3 = "101".
  logic [1:0] ds;
  always @(posedge clk) begin
    if (det_rst) begin
      ds      <= 2'd0;
      det_out <= 1'b0;
    end else begin
      det_out <= (ds == 2'd3) && det_in;
      case (ds)
        2'd0: ds <= det_in ? 2'd1 : 2'd0;
        2'd1: ds <= det_in ? 2'd1 : 2'd2;
        2'd2: ds <= det_in ? 2'd3 : 2'd0;
        default: ds <= det_in ? 2'd1 : 2'd2;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 right after driving requests; returns at posedge+2 with the grant visible.
  task automatic wait_grant(input int exp_id, input string tag);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_gnt"}, 32'(req_ready), 32'(1) << exp_id);
  endtask

  // Completes an accepted word: drops valid after the accept edge, times rsp_valid, checks the result.
  task automatic run_word(input int id, input int exp_cnt, input string tag);
    int lat = 0;
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(DW + 2));
    check({tag, "_id"},  32'(rsp_id), 32'(id));
    check({tag, "_cnt"}, 32'(rsp_count), 32'(exp_cnt));
    if (!rsp_ready) begin
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic serve(input int id, input logic [7:0] d, input int exp_cnt, input string tag);
    req_data[id*DW +: DW] = d;
    req_valid[id]         = 1'b1;
    wait_grant(id, tag);
    run_word(id, exp_cnt, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev;
    int hits;
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) step();
    check("rst_det_rst",   32'(det_rst),   32'd1);
    check("rst_det_in",    32'(det_in),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    reset = 1'b1;
    step();
    check("rel_det_rst",   32'(det_rst),   32'd0);

    serve(0, 8'hBB, 2, "bb0");
    serve(0, 8'hB0, 1, "b0");
    serve(0, 8'h00, 0, "z0");
    serve(0, 8'hFF, 0, "ff0");
    // Single match on the final bit, picked up only in DRAIN; also moves rr_ptr back to 0.
    serve(3, 8'h0B, 1, "last3");

    // All four at once with the consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'hBB;
    req_valid = '1;
    t_prev    = 0;
    for (int k = 0; k < NR; k++) begin
      wait_grant(k, "rr");
      if (k > 0) check("rr_spacing", 32'(cyc - t_prev), 32'(DW + 4));
      t_prev = cyc;
      run_word(k, 2, "rr");
    end
    step();
    rsp_ready = 1'b0;

    // Consumer stalls in RESP while another requester arrives.
    req_data[0*DW +: DW] = 8'hBB;
    req_valid[0]         = 1'b1;
    wait_grant(0, "stall");
    step();
    req_valid[0] = 1'b0;
    hits = 0;
    while (!rsp_valid && hits < 40) begin
      step();
      hits++;
    end
    req_data[1*DW +: DW] = 8'hB0;
    req_valid[1]         = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_id",    32'(rsp_id),    32'd0);
      check("stall_cnt",   32'(rsp_count), 32'd2);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    wait_grant(1, "after_stall");
    run_word(1, 1, "after_stall");

    // Reset in the middle of SHIFT aborts the word.
    req_data[3*DW +: DW] = 8'hBB;
    req_valid[3]         = 1'b1;
    wait_grant(3, "abort");
    step();
    req_valid[3] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    #1;
    check("abort_det_rst", 32'(det_rst),   32'd1);
    check("abort_busy",    32'(busy),      32'd0);
    check("abort_valid",   32'(rsp_valid), 32'd0);
    step();
    reset = 1'b1;
    hits  = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) hits++;
    end
    check("abort_no_rsp", 32'(hits), 32'd0);

    // rr_ptr back at 0: req1 wins over req2.
    req_data[1*DW +: DW] = 8'hBB;
    req_data[2*DW +: DW] = 8'hBB;
    req_valid            = 4'b0110;
    wait_grant(1, "post_rst1");
    run_word(1, 2, "post_rst1");
    wait_grant(2, "post_rst2");
    run_word(2, 2, "post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_det_scheduler
